// File: rtl/fetch_instr_queue.sv
// Fetch packet FIFO between the cache controller and decode, with registered stop_fetch
// back-pressure and flush on jump_accept. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_instr_queue #(
    parameter int DEPTH        = 8,
    parameter int DATA_W       = 128,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write_fifo,
    input  logic [DATA_W-1:0]        fetch_instr_pc,
    input  logic                     jump_accept,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     stop_fetch,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              empty, full, pop, push, drop, byp_take;
    logic [CNT_W-1:0]  count_next;

    assign empty = (count == '0);
    assign full  = (count == FULL_LVL);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp;
    // Empty queue: the incoming packet is shown to decode in the same cycle.
    assign byp      = empty && write_fifo && !jump_accept;
    assign byp_take = byp && rd_ready;
    assign rd_valid = (!empty && !jump_accept) || byp;
    assign rd_data  = byp ? fetch_instr_pc : mem[rd_ptr];
`else
    assign byp_take = 1'b0;
    assign rd_valid = !empty && !jump_accept;
    assign rd_data  = mem[rd_ptr];
`endif

    // pop only ever refers to a stored entry; a bypassed packet never touches storage.
    assign pop  = !empty && !jump_accept && rd_ready;
    assign push = write_fifo && !jump_accept && !byp_take && (!full || pop);
    assign drop = write_fifo && !jump_accept && full && !pop;

    always_comb begin
        count_next = count;
        if (jump_accept)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            stop_fetch   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            count      <= count_next;
            stop_fetch <= (count_next >= AFULL_LVL);
            if (drop)
                overflow_err <= 1'b1;
            if (jump_accept) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= fetch_instr_pc;
    end

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Instruction fetch queue directly downstream of the cache controller.
- Buffers the 128-bit fetch packets it produces on write_fifo and presents them to decode through a valid/ready handshake.
- Generates stop_fetch back-pressure to the fetch side.
- Flushes on an accepted jump.

Parameters:
- DEPTH, 8, number of packet entries; power of two, >= 4.
- DATA_W, 128, packet width; bit fields {instr1, pc1, instr0, pc0}, 32 bits each, pc0 at [31:0].
- AFULL_MARGIN, 2, free entries kept in reserve for writes already in flight when stop_fetch rises.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- write_fifo  input  1  push strobe from the cache controller.
- fetch_instr_pc  input  DATA_W  packet pushed when write_fifo=1.
- jump_accept  input  1  flush request; redirect accepted, discard all queued packets.
- rd_ready  input  1  decode accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds a valid packet.
- rd_data  output  DATA_W  oldest packet.
- stop_fetch  output  1  back-pressure to the cache controller.
- count  output  $clog2(DEPTH)+1  entries currently stored.
- overflow_err  output  1  sticky; a push was dropped because the queue was full.

Behaviour:
- Storage: DEPTH-entry register array; wr_ptr and rd_ptr of $clog2(DEPTH) bits wrap modulo DEPTH; count tracked separately, range 0..DEPTH.
- Reset (rst_n=0 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, stop_fetch=0, overflow_err=0. Array contents are don't-care.
- Reset is honoured mid-operation; all queued packets are lost.
- rd_valid = (count!=0) && !jump_accept.
- rd_data = array[rd_ptr], combinational from stored state.
- pop = rd_valid && rd_ready. On pop, rd_ptr increments and the entry is released at the clock edge.
- push = write_fifo && !jump_accept && (count<DEPTH || pop). On push, array[wr_ptr]=fetch_instr_pc and wr_ptr increments.
- Simultaneous push and pop when full is legal; count stays DEPTH.
- Simultaneous push and pop at any level leaves count unchanged.
- Full and no pop with write_fifo=1: packet dropped; overflow_err set to 1 and held until reset. Flush does not clear overflow_err.
- Empty with rd_ready=1: no effect; no underflow.
- Flush (jump_accept=1) has highest priority. At that edge: wr_ptr=0, rd_ptr=0, count=0, and the push attempted in the same cycle is discarded.
- rd_valid is 0 during the flush cycle, so decode cannot pop stale data.
- stop_fetch is registered: next value = (count_next >= DEPTH-AFULL_MARGIN). It goes 0 the cycle after a flush.
- Latency (no bypass): a packet pushed at edge N is visible on rd_data/rd_valid after edge N, i.e. one cycle later.
- Ordering: strict FIFO. No reordering or partial packets; instr1/pc1 travel with instr0/pc0.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined, when the queue is empty (count=0) and write_fifo=1 without jump_accept:
  - rd_valid=1 and rd_data=fetch_instr_pc combinationally in the same cycle.
  - If rd_ready=1, the packet is consumed directly and not written to storage; count stays 0.
  - If rd_ready=0, the packet is stored normally.
- Undefined: no combinational input-to-output path; minimum latency is one cycle as above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> rd_valid=0, stop_fetch=0, count=0, overflow_err=0.
- Basic order: push P0=0x...0000_0004, P1=0x...0000_000C on consecutive cycles with rd_ready=0, then rd_ready=1 -> rd_data P0 then P1, count 2->1->0. Without bypass, rd_valid rises exactly one cycle after first push.
- Back-pressure/full: DEPTH=8, AFULL_MARGIN=2, push 6 with rd_ready=0 -> stop_fetch=1 the cycle after the 6th push. Push 2 more -> count=8. 9th push -> dropped, overflow_err=1, rd_data still P0.
- Full push+pop: count=8, write_fifo=1 and rd_ready=1 in the same cycle -> count stays 8, P0 popped, new packet stored last; pop order verified over 8 more pops.
- Flush: count=5 with write_fifo=1, jump_accept=1 in the same cycle -> rd_valid=0 that cycle, next cycle count=0, stop_fetch=0, no packet output.
- Flush recovery: push Q0 the cycle after the flush -> Q0 is the first packet read.
- Bypass (FETCH_QUEUE_BYPASS_EN): empty queue, write_fifo=1 and rd_ready=1 with packet 0x1234... -> rd_valid=1, rd_data=0x1234... same cycle, count stays 0. Same stimulus with rd_ready=0 -> count=1.
